uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 89 ++++++++
 tb/tb_uart_tx_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit datapath: loads a parallel frame, shifts it out LSB first under
// control of an external TX FSM, and registers the selected line value onto TX_OUT.
module uart_tx_serializer #(
    parameter int FRAME_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FRAME_WIDTH-1:0] P_DATA,
    input  logic                   Data_Valid,
    input  logic                   PAR_TYP,
    input  logic                   ser_en,
    input  logic [1:0]             mux_sel,
    output logic                   ser_done,
    output logic                   ser_data,
    output logic                   par_bit,
    output logic                   TX_OUT
);

    localparam int CNT_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_WIDTH - 1);

    typedef enum logic [1:0] {
        SEL_STOP   = 2'd0,
        SEL_START  = 2'd1,
        SEL_DATA   = 2'd2,
        SEL_PARITY = 2'd3
    } line_sel_e;

    line_sel_e              sel;
    logic [FRAME_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   load, shift, last_bit;

    assign sel = line_sel_e'(mux_sel);

    always_comb begin
        load     = Data_Valid && (sel == SEL_STOP);
        shift    = ser_en && (sel == SEL_DATA);
        last_bit = shift && (cnt_q == LAST_BIT);
    end

    // Gated by reset so both read 0 during reset even for a one-bit frame.
    assign ser_done = reset & last_bit;
    assign ser_data = reset & shift_q[0];
    assign par_bit  = par_q;
    assign TX_OUT   = tx_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        if (load) begin
            shift_d = P_DATA;
            cnt_d   = '0;
            par_d   = (^P_DATA) ^ PAR_TYP;
        end else if (shift) begin
            shift_d = shift_q >> 1;
            cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (sel)
            SEL_STOP:   tx_d = 1'b1;
            SEL_START:  tx_d = 1'b0;
            SEL_DATA:   tx_d = shift_q[0];
            SEL_PARITY: tx_d = par_q;
            default:    tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: an 8-bit and a 5-bit instance share the
// FSM-side controls; each task plays one frame scenario and checks the line.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pd;
    logic [4:0] pd5;
    logic       dv, ptyp, en;
    logic [1:0] sel;

    logic done, sdata, par, tx;
    logic done5, sdata5, par5, tx5;

    logic s_done, s_sdata, s_par, s_tx;
    logic s_done5, s_par5, s_tx5;

    int passed = 0;
    int total  = 0;

    uart_tx_serializer #(.FRAME_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .P_DATA(pd), .Data_Valid(dv), .PAR_TYP(ptyp),
        .ser_en(en), .mux_sel(sel), .ser_done(done), .ser_data(sdata),
        .par_bit(par), .TX_OUT(tx)
    );

    uart_tx_serializer #(.FRAME_WIDTH(5)) dut5 (
        .clk(clk), .reset(reset), .P_DATA(pd5), .Data_Valid(dv), .PAR_TYP(ptyp),
        .ser_en(en), .mux_sel(sel), .ser_done(done5), .ser_data(sdata5),
        .par_bit(par5), .TX_OUT(tx5)
    );

    always #5 clk = ~clk;

    // One FSM cycle: drive, sample combinational outputs mid-cycle, then TX_OUT after the edge.
    task automatic cyc(input logic [1:0] m, input logic e, input logic v);
        sel = m; en = e; dv = v;
        #4;
        s_done = done; s_sdata = sdata; s_par = par;
        s_done5 = done5; s_par5 = par5;
        @(posedge clk); #1;
        s_tx = tx; s_tx5 = tx5;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pt, input logic pen,
                              input logic exp_par, input logic skip_idle,
                              input logic next_load, input logic [7:0] next_data,
                              input string name, output logic [10:0] bits);
        int k;
        k = 10;
        bits = '1;
        ptyp = pt;
        if (!skip_idle) begin
            pd = data;
            cyc(2'd0, 1'b0, 1'b1);
            total++;
            if (s_tx !== 1'b1) $display("FAIL %s idle: got %b want 1", name, s_tx);
            else passed++;
        end
        cyc(2'd1, 1'b1, 1'b0);
        bits[k] = s_tx; k--;
        total++;
        if (s_tx !== 1'b0) $display("FAIL %s start: got %b want 0", name, s_tx);
        else passed++;
        total++;
        if (s_par !== exp_par) $display("FAIL %s par_bit: got %b want %b", name, s_par, exp_par);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            cyc(2'd2, 1'b1, 1'b0);
            bits[k] = s_tx; k--;
            total++;
            if (s_tx !== data[i]) $display("FAIL %s data[%0d]: got %b want %b", name, i, s_tx, data[i]);
            else passed++;
            total++;
            if (s_done !== (i == 7)) $display("FAIL %s ser_done[%0d]: got %b want %b", name, i, s_done, (i == 7));
            else passed++;
        end
        if (pen) begin
            cyc(2'd3, 1'b0, 1'b0);
            bits[k] = s_tx; k--;
            total++;
            if (s_tx !== exp_par) $display("FAIL %s parity: got %b want %b", name, s_tx, exp_par);
            else passed++;
        end
        pd = next_data;
        cyc(2'd0, 1'b0, next_load);
        bits[k] = s_tx;
        total++;
        if (s_tx !== 1'b1) $display("FAIL %s stop: got %b want 1", name, s_tx);
        else passed++;
    endtask

    task automatic test_reset();
        pd = 8'hA5; pd5 = 5'h1F; dv = 1'b1; ptyp = 1'b1; en = 1'b1; sel = 2'd2;
        reset = 1'b0;
        #12;
        total++;
        if (tx !== 1'b1) $display("FAIL reset TX_OUT: got %b want 1", tx); else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL reset ser_done: got %b want 0", done); else passed++;
        total++;
        if (sdata !== 1'b0) $display("FAIL reset ser_data: got %b want 0", sdata); else passed++;
        total++;
        if (par !== 1'b0) $display("FAIL reset par_bit: got %b want 0", par); else passed++;
        total++;
        if (tx5 !== 1'b1) $display("FAIL reset TX_OUT w5: got %b want 1", tx5); else passed++;
        sel = 2'd0; en = 1'b0; dv = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_even_parity();
        logic [10:0] bits;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "evenA5", bits);
        total++;
        if (bits !== 11'b01010010101) $display("FAIL evenA5 line: got %b want 01010010101", bits);
        else passed++;
    endtask

    task automatic test_odd_parity();
        logic [10:0] bits;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "odd01", bits);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "even01_nopar", bits);
        // no parity bit: stop directly after the 8th data bit
        total++;
        if (bits[10:1] !== 10'b0100000001) $display("FAIL even01_nopar line: got %b want 0100000001", bits[10:1]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [10:0] b1, b2;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, "b2b_3C", b1);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "b2b_C3", b2);
        total++;
        if ({b1[0], b2[10]} !== 2'b10) $display("FAIL b2b stop->start: got %b want 10", {b1[0], b2[10]});
        else passed++;
    endtask

    task automatic test_ignore_busy();
        logic [7:0] exp_bits;
        exp_bits = 8'b0000_1111;
        pd = 8'h0F; ptyp = 1'b0;
        cyc(2'd0, 1'b0, 1'b1);
        cyc(2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                pd = 8'hFF;
                cyc(2'd2, 1'b1, 1'b1);
            end else begin
                cyc(2'd2, 1'b1, 1'b0);
            end
            total++;
            if (s_tx !== exp_bits[i]) $display("FAIL busy data[%0d]: got %b want %b", i, s_tx, exp_bits[i]);
            else passed++;
        end
        cyc(2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe();
        logic [10:0] bits;
        pd = 8'h9B; ptyp = 1'b0;
        cyc(2'd0, 1'b0, 1'b1);
        cyc(2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(2'd2, 1'b1, 1'b0);
        total++;
        if (tx !== 1'b0) $display("FAIL midrst pre TX_OUT: got %b want 0", tx); else passed++;
        sel = 2'd2; en = 1'b1; dv = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++;
        if (tx !== 1'b1) $display("FAIL midrst TX_OUT: got %b want 1", tx); else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL midrst ser_done: got %b want 0", done); else passed++;
        total++;
        if (sdata !== 1'b0) $display("FAIL midrst ser_data: got %b want 0", sdata); else passed++;
        total++;
        if (par !== 1'b0) $display("FAIL midrst par_bit: got %b want 0", par); else passed++;
        sel = 2'd0; en = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "after_rst5A", bits);
    endtask

    task automatic test_width5();
        logic [4:0] d5;
        d5 = 5'h15;
        pd5 = d5; ptyp = 1'b0;
        cyc(2'd0, 1'b0, 1'b1);
        cyc(2'd1, 1'b1, 1'b0);
        total++;
        if (s_par5 !== 1'b1) $display("FAIL w5 par_bit: got %b want 1", s_par5); else passed++;
        total++;
        if (s_tx5 !== 1'b0) $display("FAIL w5 start: got %b want 0", s_tx5); else passed++;
        for (int i = 0; i < 5; i++) begin
            cyc(2'd2, 1'b1, 1'b0);
            total++;
            if (s_tx5 !== d5[i]) $display("FAIL w5 data[%0d]: got %b want %b", i, s_tx5, d5[i]);
            else passed++;
            total++;
            if (s_done5 !== (i == 4)) $display("FAIL w5 ser_done[%0d]: got %b want %b", i, s_done5, (i == 4));
            else passed++;
        end
        cyc(2'd3, 1'b0, 1'b0);
        total++;
        if (s_tx5 !== 1'b1) $display("FAIL w5 parity: got %b want 1", s_tx5); else passed++;
        cyc(2'd0, 1'b0, 1'b0);
        total++;
        if (s_tx5 !== 1'b1) $display("FAIL w5 stop: got %b want 1", s_tx5); else passed++;
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_back_to_back();
        test_ignore_busy();
        test_reset_midframe();
        test_width5();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
